// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared constants for the WS2812 pixel assembler.
//   - FSM state encodings (4-bit)
//   - legal channel counts (GRB = 3, GRBW = 4)
//   - LED count used after reset until the first write_config
package ws2812_pkg;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] HOLD      = 4'd1;
  localparam logic [3:0] FIFO_WAIT = 4'd2;
  localparam logic [3:0] CAPTURE   = 4'd3;
  localparam logic [3:0] WRITE     = 4'd4;

  localparam int CH_RGB  = 3;
  localparam int CH_RGBW = 4;

  localparam int DEFAULT_LED_COUNT = 10;

endpackage

// File: rtl/ws2812_chan_scale.sv
// ws2812_chan_scale: scales one colour byte by a global brightness.
//   din        : raw channel value
//   brightness : 0..255, 255 passes the byte through, 0 blanks it
//   dout       : (din * (brightness + 1)) >> 8
// Purely combinational; only used when WS2812_BRIGHTNESS_EN is defined.
module ws2812_chan_scale #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  input  logic [7:0]   brightness,
  output logic [W-1:0] dout
);

  // brightness+1 needs 9 bits; the product of a W-bit byte and a gain of at
  // most 256 always fits in W+8 bits (16 bits for byte-wide channels).
  logic [8:0]   gain;
  logic [W+7:0] prod;

  assign gain = {1'b0, brightness} + 9'd1;
  assign prod = (W+8)'(din) * (W+8)'(gain);
  assign dout = W'(prod >> 8);

endmodule

// File: rtl/ws2812_pixel_assembler.sv
// ws2812_pixel_assembler: pops CHANNELS bytes per pixel from a write FIFO,
// packs them first-byte-in-MSBs (G, R, B, W) and hands the pixel with its LED
// address to the pixel store through a write/wr_ready handshake.
//   clk, rst        : clock, synchronous active-high reset
//   f_empty         : FIFO empty flag
//   fifo_read_data  : FIFO data, valid the cycle after fifo_read_en
//   fifo_read_en    : one-cycle pop strobe
//   num_leds        : LED count, latched on write_config (0 stored as 1)
//   write_config    : latch num_leds and abort the pixel in progress
//   brightness      : global dimming, only with WS2812_BRIGHTNESS_EN defined
//   pixel_data      : assembled pixel word
//   address         : LED index of pixel_data
//   write           : pixel valid, held until wr_ready
//   wr_ready        : downstream accepts the pixel
//   frame_done      : one-cycle pulse after the last LED of a frame is taken
// Optional feature macro: WS2812_BRIGHTNESS_EN.
module ws2812_pixel_assembler
  import ws2812_pkg::*;
#(
  parameter int FIFO_WIDTH   = 8,
  parameter int CHANNELS     = CH_RGB,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEFAULT_LEDS = DEFAULT_LED_COUNT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           f_empty,
  input  logic [FIFO_WIDTH-1:0]          fifo_read_data,
  output logic                           fifo_read_en,
  input  logic [ADDR_WIDTH-1:0]          num_leds,
  input  logic                           write_config,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]                     brightness,
`endif
  output logic [CHANNELS*FIFO_WIDTH-1:0] pixel_data,
  output logic [ADDR_WIDTH-1:0]          address,
  output logic                           write,
  input  logic                           wr_ready,
  output logic                           frame_done
);

  localparam int CH_W = $clog2(CHANNELS);

  if (CHANNELS != CH_RGB && CHANNELS != CH_RGBW) begin : g_bad_channels
    $error("ws2812_pixel_assembler: CHANNELS must be 3 or 4");
  end

  logic [3:0]                     state, state_n;
  logic [CH_W-1:0]                ch, ch_n, lane;
  logic [ADDR_WIDTH-1:0]          depth, last_addr, addr_n;
  logic [CHANNELS*FIFO_WIDTH-1:0] pix_n;
  logic [FIFO_WIDTH-1:0]          cap_byte;
  logic                           rd_en_n, write_n, done_n, ch_last;

`ifdef WS2812_BRIGHTNESS_EN
  ws2812_chan_scale #(.W(FIFO_WIDTH)) u_scale (
    .din        (fifo_read_data),
    .brightness (brightness),
    .dout       (cap_byte)
  );
`else
  assign cap_byte = fifo_read_data;
`endif

  assign ch_last   = (ch == CH_W'(CHANNELS - 1));
  assign lane      = CH_W'(CHANNELS - 1) - ch;
  assign last_addr = depth - ADDR_WIDTH'(1);

  // State register: write_config aborts to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (rst || write_config) state <= IDLE;
    else                     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = HOLD;
      HOLD:      state_n = f_empty ? HOLD : FIFO_WAIT;
      FIFO_WAIT: state_n = CAPTURE;
      CAPTURE:   state_n = ch_last ? WRITE : HOLD;
      WRITE:     state_n = wr_ready ? HOLD : WRITE;
      default:   state_n = IDLE;
    endcase
  end

  // Output/datapath next values; all outputs are registered below.
  always_comb begin
    rd_en_n = 1'b0;
    write_n = write;
    done_n  = 1'b0;
    ch_n    = ch;
    addr_n  = address;
    pix_n   = pixel_data;
    case (state)
      IDLE: ch_n = '0;
      HOLD: rd_en_n = !f_empty;
      CAPTURE: begin
        pix_n[int'(lane)*FIFO_WIDTH +: FIFO_WIDTH] = cap_byte;
        if (ch_last) begin
          ch_n    = '0;
          write_n = 1'b1;
        end else begin
          ch_n = ch + CH_W'(1);
        end
      end
      WRITE: begin
        if (wr_ready) begin
          write_n = 1'b0;
          if (address == last_addr) begin
            addr_n = '0;
            done_n = 1'b1;
          end else begin
            addr_n = address + ADDR_WIDTH'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // The abort leaves pixel_data as is; only control and position are cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_read_en <= 1'b0;
      write        <= 1'b0;
      frame_done   <= 1'b0;
      pixel_data   <= '0;
      address      <= '0;
      ch           <= '0;
      depth        <= ADDR_WIDTH'(DEFAULT_LEDS);
    end else if (write_config) begin
      depth        <= (num_leds == '0) ? ADDR_WIDTH'(1) : num_leds;
      fifo_read_en <= 1'b0;
      write        <= 1'b0;
      frame_done   <= 1'b0;
      address      <= '0;
      ch           <= '0;
    end else begin
      fifo_read_en <= rd_en_n;
      write        <= write_n;
      frame_done   <= done_n;
      pixel_data   <= pix_n;
      address      <= addr_n;
      ch           <= ch_n;
    end
  end

endmodule

// File: tb/tb_ws2812_pixel_assembler.sv
// Bench for ws2812_pixel_assembler: one GRB (3-channel) and one GRBW
// (4-channel) instance share clock, reset, config and wr_ready; each has its
// own FIFO model and a reference model that packs the popped bytes and
// tracks the expected LED address / frame_done from the LED count.
module tb_ws2812_pixel_assembler;

  logic        clk = 1'b0;
  logic        rst, write_config, wr_ready, hold_empty;
  logic [15:0] num_leds;
  int          depth;
  int          n_assert = 0;
  int          n_fail   = 0;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]  brightness;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference view of one stored byte.
  function automatic logic [7:0] model_byte(input logic [7:0] b);
`ifdef WS2812_BRIGHTNESS_EN
    int p;
    p = int'(b) * (int'(brightness) + 1);
    return 8'(p / 256);
`else
    return b;
`endif
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int CH = (g == 0) ? 3 : 4;
    logic            f_empty = 1'b1;
    logic [7:0]      rd_data = '0;
    logic            rd_en, wr, fd;
    logic [CH*8-1:0] pix, prev_pix, last_pix;
    logic [15:0]     addr, prev_addr, last_addr;
    logic [7:0]      fq[$];
    logic [7:0]      cons[$];
    int              exp_addr = 0, pops = 0, accepts = 0, fd_count = 0;
    bit              exp_fd = 0, acc_prev = 0, stall_prev = 0;

    ws2812_pixel_assembler #(
      .FIFO_WIDTH(8), .CHANNELS(CH), .ADDR_WIDTH(16), .DEFAULT_LEDS(10)
    ) dut (
      .clk(clk), .rst(rst), .f_empty(f_empty), .fifo_read_data(rd_data),
      .fifo_read_en(rd_en), .num_leds(num_leds), .write_config(write_config),
`ifdef WS2812_BRIGHTNESS_EN
      .brightness(brightness),
`endif
      .pixel_data(pix), .address(addr), .write(wr), .wr_ready(wr_ready),
      .frame_done(fd)
    );

    // FIFO model: pop on the strobe, data visible the following cycle.
    always @(posedge clk) begin
      if (rd_en && fq.size() > 0) begin
        logic [7:0] b;
        b = fq.pop_front();
        rd_data <= b;
        cons.push_back(model_byte(b));
        pops++;
      end
      if (rst || write_config) cons.delete();
    end

    always @(negedge clk) begin
      f_empty = (fq.size() == 0) || hold_empty;
      if (rst) begin
        exp_addr = 0; exp_fd = 0; acc_prev = 0; stall_prev = 0;
      end else begin
        check($sformatf("frame_done_ch%0d", CH), fd, exp_fd);
        if (acc_prev) check($sformatf("write_drop_ch%0d", CH), wr, 1'b0);
        if (stall_prev) begin
          check($sformatf("stall_write_ch%0d", CH), wr, 1'b1);
          check($sformatf("stall_pix_ch%0d", CH), pix, prev_pix);
          check($sformatf("stall_addr_ch%0d", CH), addr, prev_addr);
        end
        if (wr) check($sformatf("pop_during_write_ch%0d", CH), rd_en, 1'b0);
        if (rd_en) check($sformatf("pop_nonempty_ch%0d", CH), fq.size() > 0, 1'b1);
        if (fd) fd_count++;
        exp_fd = 0; acc_prev = 0;
        if (write_config) begin
          exp_addr = 0;
        end else if (wr && wr_ready) begin
          logic [63:0] e;
          e = '0;
          check($sformatf("bytes_per_pixel_ch%0d", CH), cons.size(), CH);
          for (int i = 0; i < CH; i++) e = (e << 8) | ((i < cons.size()) ? cons[i] : 8'h00);
          check($sformatf("pixel_ch%0d", CH), pix, e);
          check($sformatf("address_ch%0d", CH), addr, exp_addr);
          for (int i = 0; i < CH; i++) if (cons.size() > 0) void'(cons.pop_front());
          exp_fd   = (exp_addr == depth - 1);
          exp_addr = exp_fd ? 0 : exp_addr + 1;
          accepts++; last_pix = pix; last_addr = addr; acc_prev = 1;
        end
        stall_prev = wr && !wr_ready && !write_config;
        prev_pix = pix; prev_addr = addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [15:0] n);
    num_leds = n; write_config = 1'b1; depth = (n == 0) ? 1 : int'(n);
    tick();
    write_config = 1'b0;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n * 3; i++) u[0].fq.push_back(8'($urandom));
    for (int i = 0; i < n * 4; i++) u[1].fq.push_back(8'($urandom));
  endtask

  // Run until both FIFOs are empty and every pixel has been taken.
  task automatic drain(input bit rnd);
    int cyc = 0;
    while (cyc < 3000 && !(u[0].fq.size() == 0 && u[1].fq.size() == 0 &&
           u[0].cons.size() == 0 && u[1].cons.size() == 0 && !u[0].wr && !u[1].wr)) begin
      tick();
      if (rnd) begin
        wr_ready   = 1'($urandom_range(0, 1));
        hold_empty = ($urandom_range(0, 3) == 0);
      end
      cyc++;
    end
    wr_ready = 1'b1; hold_empty = 1'b0;
    check("drain_timeout", cyc < 3000, 1'b1);
    repeat (3) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, p0, p1;
    rst = 1'b1; write_config = 1'b0; num_leds = '0; wr_ready = 1'b1;
    hold_empty = 1'b0; depth = 10;
`ifdef WS2812_BRIGHTNESS_EN
    brightness = 8'd255;
`endif
    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_en_ch3", u[0].rd_en, 1'b0);
    check("rst_write_ch3", u[0].wr, 1'b0);
    check("rst_fd_ch3", u[0].fd, 1'b0);
    check("rst_pix_ch3", u[0].pix, 24'h0);
    check("rst_addr_ch3", u[0].addr, 16'h0);
    check("rst_write_ch4", u[1].wr, 1'b0);
    check("rst_pix_ch4", u[1].pix, 32'h0);
    check("rst_addr_ch4", u[1].addr, 16'h0);
    tick();
    rst = 1'b0;

    // GRB pixel 11,22,33
    u[0].fq.push_back(8'h11); u[0].fq.push_back(8'h22); u[0].fq.push_back(8'h33);
    drain(1'b0);
    check("t1_pixel", u[0].last_pix, 24'h112233);
    check("t1_addr", u[0].last_addr, 16'd0);
    check("t1_pops", u[0].pops, 3);
    check("t1_accepts", u[0].accepts, 1);

    // GRBW, two pixels
    for (int k = 0; k < 2; k++) begin
      u[1].fq.push_back(8'hAA); u[1].fq.push_back(8'hBB);
      u[1].fq.push_back(8'hCC); u[1].fq.push_back(8'hDD);
    end
    drain(1'b0);
    check("t2_pixel", u[1].last_pix, 32'hAABBCCDD);
    check("t2_addr", u[1].last_addr, 16'd1);

    // Default depth of 10: GRB instance wraps after its 10th pixel.
    push_rand(9);
    drain(1'b1);

    // num_leds = 2, five pixels: frame_done on the 2nd and 4th.
    cfg(16'd2);
    u[0].fd_count = 0; u[1].fd_count = 0;
    push_rand(5);
    drain(1'b0);
    check("t3_fd_count_ch3", u[0].fd_count, 2);
    check("t3_fd_count_ch4", u[1].fd_count, 2);

    // Downstream stall of 7 cycles.
    wr_ready = 1'b0;
    push_rand(1);
    cyc = 0;
    while (!(u[0].wr && u[1].wr) && cyc < 200) begin tick(); cyc++; end
    check("t4_reach_write", cyc < 200, 1'b1);
    p0 = u[0].pops; p1 = u[1].pops;
    repeat (7) tick();
    check("t4_no_pops_ch3", u[0].pops, p0);
    check("t4_no_pops_ch4", u[1].pops, p1);
    wr_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t4_accept_ch3", u[0].wr, 1'b0);
    check("t4_accept_ch4", u[1].wr, 1'b0);
    drain(1'b0);

    // Partial pixel with a stuttering FIFO, then abort to depth 1.
    for (int i = 0; i < 2; i++) begin
      u[0].fq.push_back(8'($urandom)); u[1].fq.push_back(8'($urandom));
    end
    for (int i = 0; i < 30; i++) begin tick(); hold_empty = 1'($urandom_range(0, 1)); end
    hold_empty = 1'b0;
    repeat (5) tick();
    check("t5_bytes_popped_ch3", u[0].fq.size(), 0);
    check("t5_bytes_popped_ch4", u[1].fq.size(), 0);
    check("t5_no_write_ch3", u[0].wr, 1'b0);
    cfg(16'd0);
    @(negedge clk);
    check("t5_abort_addr_ch3", u[0].addr, 16'd0);
    check("t5_abort_addr_ch4", u[1].addr, 16'd0);
    tick();
    u[0].fd_count = 0; u[1].fd_count = 0;
    push_rand(3);
    drain(1'b1);
    check("t5_fd_count_ch3", u[0].fd_count, 3);
    check("t5_fd_count_ch4", u[1].fd_count, 3);

    // Random depth, random backpressure and FIFO stutter.
    for (int r = 0; r < 3; r++) begin
      cfg(16'($urandom_range(1, 6)));
      push_rand(int'($urandom_range(4, 10)));
      drain(1'b1);
    end

`ifdef WS2812_BRIGHTNESS_EN
    begin
      logic [7:0] br[3];
      logic [7:0] ex[3];
      br[0] = 8'd127; ex[0] = 8'h7F;
      br[1] = 8'd255; ex[1] = 8'hFF;
      br[2] = 8'd0;   ex[2] = 8'h00;
      for (int k = 0; k < 3; k++) begin
        brightness = br[k];
        for (int i = 0; i < 3; i++) u[0].fq.push_back(8'hFF);
        for (int i = 0; i < 4; i++) u[1].fq.push_back(8'hFF);
        drain(1'b0);
        check($sformatf("bright%0d_ch3", br[k]), u[0].last_pix, {ex[k], ex[k], ex[k]});
        check($sformatf("bright%0d_ch4", br[k]), u[1].last_pix, {ex[k], ex[k], ex[k], ex[k]});
      end
    end
`endif

    check("final_fifo_ch3", u[0].fq.size(), 0);
    check("final_fifo_ch4", u[1].fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
